// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback for the shared-memory datapath.
// Optional feature: define MCC_BNE_EN to add bne (op 000101) through state BNE (12).
//
// state   | meaning
// --------+-------------------------------------------------------------
// FETCH   | read instruction at PC, PC+4 -> PC when memory is ready
// DECODE  | read registers, precompute branch target into ALUOut
// MEMADR  | compute A + signimm for lw/sw
// MEMRD   | read data memory at ALUOut, wait for memready
// MEMWB   | write loaded data to rt
// MEMWR   | write B to memory at ALUOut, held until memready
// EXECUTE | R-type ALU operation on A and B
// ALUWB   | write ALUOut to rd
// BEQ     | compare A and B, take branch target on zero
// ADDIEX  | A + signimm
// ADDIWB  | write ALUOut to rt
// JUMP    | load jump target into PC
// BNE     | compare A and B, take branch target on not-zero (MCC_BNE_EN only)
module mc_controller #(
    parameter bit SINGLE_CYCLE_MEM = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
`ifdef MCC_BNE_EN
        , S_BNE   = 4'd12
`endif
    } state_t;

    state_t     state_q;
    logic       mem_rdy;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       irwrite_s;
    logic       pcen_s;
    logic       regwrite_s;
    logic       memwrite_s;

    assign mem_rdy = SINGLE_CYCLE_MEM ? 1'b1 : memready;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            F_ADD:   funct_alu = ALU_ADD;
            F_SUB:   funct_alu = ALU_SUB;
            F_AND:   funct_alu = ALU_AND;
            F_OR:    funct_alu = ALU_OR;
            F_SLT:   funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    // illegal is raised for exactly the cycle after an undecodable instruction or a stray state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state_q)
                S_FETCH:   if (mem_rdy) state_q <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_RTYPE: begin
                            if (funct_ok) begin
                                state_q <= S_EXECUTE;
                            end else begin
                                state_q <= S_FETCH;
                                illegal <= 1'b1;
                            end
                        end
                        OP_BEQ:  state_q <= S_BEQ;
                        OP_ADDI: state_q <= S_ADDIEX;
                        OP_J:    state_q <= S_JUMP;
`ifdef MCC_BNE_EN
                        OP_BNE:  state_q <= S_BNE;
`endif
                        default: begin
                            state_q <= S_FETCH;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR:  state_q <= (op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (mem_rdy) state_q <= S_MEMWB;
                S_MEMWB:   state_q <= S_FETCH;
                S_MEMWR:   if (mem_rdy) state_q <= S_FETCH;
                S_EXECUTE: state_q <= S_ALUWB;
                S_ALUWB:   state_q <= S_FETCH;
                S_BEQ:     state_q <= S_FETCH;
                S_ADDIEX:  state_q <= S_ADDIWB;
                S_ADDIWB:  state_q <= S_FETCH;
                S_JUMP:    state_q <= S_FETCH;
`ifdef MCC_BNE_EN
                S_BNE:     state_q <= S_FETCH;
`endif
                default: begin
                    state_q <= S_FETCH;
                    illegal <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alucontrol = ALU_ADD;
        pcsrc      = 2'b00;
        irwrite_s  = 1'b0;
        pcen_s     = 1'b0;
        regwrite_s = 1'b0;
        memwrite_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b01;
                irwrite_s = mem_rdy;
                pcen_s    = mem_rdy;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BEQ: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen_s     = zero;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB:  regwrite_s = 1'b1;
            S_JUMP: begin
                pcsrc  = 2'b10;
                pcen_s = 1'b1;
            end
`ifdef MCC_BNE_EN
            S_BNE: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen_s     = ~zero;
            end
`endif
            default: ;
        endcase
    end

    // Architectural writes are blocked combinationally so nothing leaks out while reset is held.
    assign irwrite  = irwrite_s  & reset;
    assign pcen     = pcen_s     & reset;
    assign regwrite = regwrite_s & reset;
    assign memwrite = memwrite_s & reset;
    assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed cases then random instruction streams
// compared against an instruction-level model of the expected state walk and control values.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    bit pend_ill = 1'b0;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic [1:0] pcsrc;
        logic       pcen;
    } outs_t;

    typedef struct packed {
        logic [3:0] st;
        logic       mr;
    } step_t;

    outs_t obs;
    assign obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, alucontrol, pcsrc, pcen};

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memready   (memready),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction classes: 0 lw, 1 sw, 2 R-type, 3 beq, 4 addi, 5 j, 6 bne, 7 illegal.
    function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011: return 0;
            6'b101011: return 1;
            6'b000000: return (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                               f == 6'b100101 || f == 6'b101010) ? 2 : 7;
            6'b000100: return 3;
            6'b001000: return 4;
            6'b000010: return 5;
`ifdef MCC_BNE_EN
            6'b000101: return 6;
`endif
            default:   return 7;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Control values each step of an instruction must present.
    function automatic outs_t expect_outs(input int st, input logic mr, input logic z, input logic [5:0] f);
        outs_t o;
        o = '0;
        o.alucontrol = 3'b010;
        case (st)
            0:  begin o.alusrcb = 2'b01; o.irwrite = mr; o.pcen = mr; end
            1:  o.alusrcb = 2'b11;
            2:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            3:  o.iord = 1'b1;
            4:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
            5:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
            6:  begin o.alusrca = 1'b1; o.alucontrol = alu_of(f); end
            7:  begin o.regdst = 1'b1; o.regwrite = 1'b1; end
            8:  begin o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = z; end
            9:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            10: o.regwrite = 1'b1;
            11: begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
            12: begin o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = ~z; end
            default: ;
        endcase
        return o;
    endfunction

    // Runs one instruction; wf/wm are memready-low cycles in fetch and the data access.
    // abort >= 0 stops after that many steps, leaving the DUT mid-instruction.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int wf, input int wm, input int abort);
        step_t q[$];
        int    k;
        outs_t exp_o;
        logic  exp_ill;
        k = kind_of(o, f);
        for (int i = 0; i < wf; i++) q.push_back('{4'd0, 1'b0});
        q.push_back('{4'd0, 1'b1});
        q.push_back('{4'd1, 1'($urandom_range(0, 1))});
        case (k)
            0: begin
                q.push_back('{4'd2, 1'($urandom_range(0, 1))});
                for (int i = 0; i < wm; i++) q.push_back('{4'd3, 1'b0});
                q.push_back('{4'd3, 1'b1});
                q.push_back('{4'd4, 1'($urandom_range(0, 1))});
            end
            1: begin
                q.push_back('{4'd2, 1'($urandom_range(0, 1))});
                for (int i = 0; i < wm; i++) q.push_back('{4'd5, 1'b0});
                q.push_back('{4'd5, 1'b1});
            end
            2: begin
                q.push_back('{4'd6, 1'($urandom_range(0, 1))});
                q.push_back('{4'd7, 1'($urandom_range(0, 1))});
            end
            3: q.push_back('{4'd8, 1'($urandom_range(0, 1))});
            4: begin
                q.push_back('{4'd9, 1'($urandom_range(0, 1))});
                q.push_back('{4'd10, 1'($urandom_range(0, 1))});
            end
            5: q.push_back('{4'd11, 1'($urandom_range(0, 1))});
            6: q.push_back('{4'd12, 1'($urandom_range(0, 1))});
            default: ;
        endcase
        for (int i = 0; i < q.size(); i++) begin
            if (abort >= 0 && i >= abort) break;
            @(negedge clk);
            if (i == 0) begin
                op    = o;
                funct = f;
                zero  = z;
            end
            memready = q[i].mr;
            #1;
            exp_o   = expect_outs(int'(q[i].st), q[i].mr, z, f);
            exp_ill = (i == 0) ? pend_ill : 1'b0;
            checks++;
            assert (state === q[i].st) else begin
                errors++;
                $error("FAIL state op=%b step=%0d observed=%0d expected=%0d", o, i, state, q[i].st);
            end
            checks++;
            assert (obs === exp_o) else begin
                errors++;
                $error("FAIL outputs op=%b funct=%b step=%0d observed=%h expected=%h", o, f, i, obs, exp_o);
            end
            checks++;
            assert (illegal === exp_ill) else begin
                errors++;
                $error("FAIL illegal op=%b step=%0d observed=%b expected=%b", o, i, illegal, exp_ill);
            end
        end
        pend_ill = (k == 7) && (abort < 0);
    endtask

    task automatic check_reset_quiet(input string tag);
        checks++;
        assert (state === 4'd0 && memwrite === 1'b0 && irwrite === 1'b0 && pcen === 1'b0 &&
                regwrite === 1'b0 && illegal === 1'b0) else begin
            errors++;
            $error("FAIL %s observed state=%0d mw=%b ir=%b pcen=%b rw=%b ill=%b expected 0/0/0/0/0/0",
                   tag, state, memwrite, irwrite, pcen, regwrite, illegal);
        end
    endtask

    initial begin
        logic [5:0] ro, rf;
        int         pick;
        reset    = 1'b0;
        memready = 1'b1;
        op       = 6'b000000;
        funct    = 6'b000000;
        zero     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_quiet("reset_state");
        @(posedge clk);
        #2 reset = 1'b1;

        run_instr(6'b100011, 6'b000000, 1'b0, 0, 0, -1);   // lw, memready high: 5 cycles
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 3, -1);   // sw, 3 wait cycles in MEMWR
        run_instr(6'b000000, 6'b101010, 1'b0, 0, 0, -1);   // slt
        run_instr(6'b000000, 6'b001000, 1'b0, 0, 0, -1);   // bad funct
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, -1);   // beq taken
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0, -1);   // beq not taken
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, -1);   // j
        run_instr(6'b000101, 6'b000000, 1'b0, 0, 0, -1);   // bne (or illegal)
        run_instr(6'b001000, 6'b000000, 1'b1, 2, 0, -1);   // addi after fetch wait
        run_instr(6'b100011, 6'b000000, 1'b0, 1, 2, -1);   // lw with waits

        // Abort a store while memwrite is asserted.
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 3, 4);
        #1;
        reset    = 1'b0;
        memready = 1'b1;
        #1;
        check_reset_quiet("reset_abort_memwr");
        pend_ill = 1'b0;
        @(posedge clk);
        #1;
        check_reset_quiet("reset_held_edge");
        #1 reset = 1'b1;

        for (int n = 0; n < 300; n++) begin
            pick = int'($urandom_range(0, 7));
            rf   = 6'($urandom);
            case (pick)
                0: ro = 6'b100011;
                1: ro = 6'b101011;
                2: begin
                    ro = 6'b000000;
                    if ($urandom_range(0, 4) != 0) begin
                        case ($urandom_range(0, 4))
                            0: rf = 6'b100000;
                            1: rf = 6'b100010;
                            2: rf = 6'b100100;
                            3: rf = 6'b100101;
                            default: rf = 6'b101010;
                        endcase
                    end
                end
                3: ro = 6'b000100;
                4: ro = 6'b001000;
                5: ro = 6'b000010;
                6: ro = 6'b000101;
                default: ro = 6'($urandom);
            endcase
            run_instr(ro, rf, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
